// File: rtl/fft256_seq_ctrl_if.sv
// Handshake/control bundle between the FFT sequencer and its stream ports and datapath.
// The master modport is the sequencer; the slave modport is the stream source plus butterfly/RAM side.
interface fft256_seq_ctrl_if;
  logic       inv;
  logic       valid_in;
  logic       sop_in;
  logic       in_ready;
  logic       ld_we;
  logic [7:0] ld_addr;
  logic       bf_en;
  logic [7:0] rd_addr_p;
  logic [7:0] rd_addr_q;
  logic [6:0] tw_addr;
  logic       tw_conj;
  logic       bf_scale;
  logic       wb_en;
  logic [7:0] wb_addr_p;
  logic [7:0] wb_addr_q;
  logic [2:0] stage;
  logic       out_re;
  logic [7:0] out_addr;
  logic       valid_out;
  logic       sop_out;
  logic       busy;
  logic       sop_err;

  modport master (
    input  inv, valid_in, sop_in,
    output in_ready, ld_we, ld_addr, bf_en, rd_addr_p, rd_addr_q, tw_addr, tw_conj,
           bf_scale, wb_en, wb_addr_p, wb_addr_q, stage, out_re, out_addr,
           valid_out, sop_out, busy, sop_err
  );

  modport slave (
    output inv, valid_in, sop_in,
    input  in_ready, ld_we, ld_addr, bf_en, rd_addr_p, rd_addr_q, tw_addr, tw_conj,
           bf_scale, wb_en, wb_addr_p, wb_addr_q, stage, out_re, out_addr,
           valid_out, sop_out, busy, sop_err
  );
endinterface

// File: rtl/fft256_seq_ctrl.sv
// Load / compute / read-out sequencer for the 256-point in-place radix-2 DIT FFT.
// Optional macro FFT256_CTRL_SCALE_EN: when defined, every butterfly issue also requests a 1/2 scale.
module fft256_seq_ctrl #(
  parameter int N      = 256,
  parameter int LOGN   = 8,
  parameter int BF_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  fft256_seq_ctrl_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DRAIN, S_OUT} state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_stage;
  logic [3:0] r_drain;
  logic       r_inReady;
  logic       r_ldWe;
  logic [7:0] r_ldAddr;
  logic       r_bfEn;
  logic [7:0] r_rdP;
  logic [7:0] r_rdQ;
  logic [6:0] r_twAddr;
  logic       r_twConj;
  logic       r_outRe;
  logic [7:0] r_outAddr;
  logic       r_validOut;
  logic       r_sopOut;
  logic       r_busy;
  logic       r_sopErr;

  logic [BF_LAT-1:0] r_pipeEn;
  logic [7:0]        r_pipeP [BF_LAT];
  logic [7:0]        r_pipeQ [BF_LAT];

  logic w_accept;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Packs {p, q, twiddle} for butterfly b of stage s.
  function automatic logic [22:0] bflyAddr(input logic [6:0] b, input logic [2:0] s);
    logic [7:0] bw, span, mask, p;
    bw   = {1'b0, b};
    span = 8'd1 << s;
    mask = span - 8'd1;
    p    = ((bw >> s) << ({1'b0, s} + 4'd1)) | (bw & mask);
    return {p, p + span, 7'((bw & mask) << (3'd7 - s))};
  endfunction

  assign w_accept = bus.valid_in & r_inReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_drain    <= '0;
      r_inReady  <= 1'b0;
      r_ldWe     <= 1'b0;
      r_ldAddr   <= '0;
      r_bfEn     <= 1'b0;
      r_rdP      <= '0;
      r_rdQ      <= '0;
      r_twAddr   <= '0;
      r_twConj   <= 1'b0;
      r_outRe    <= 1'b0;
      r_outAddr  <= '0;
      r_validOut <= 1'b0;
      r_sopOut   <= 1'b0;
      r_busy     <= 1'b0;
      r_sopErr   <= 1'b0;
    end else begin
      r_ldWe     <= 1'b0;
      r_sopErr   <= 1'b0;
      r_bfEn     <= 1'b0;
      r_outRe    <= 1'b0;
      r_validOut <= r_outRe;
      r_sopOut   <= r_outRe && (r_outAddr == 8'd0);
      case (r_state)
        S_IDLE: begin
          r_inReady <= 1'b1;
          r_busy    <= 1'b0;
          r_stage   <= '0;
          if (w_accept && bus.sop_in) begin
            r_ldWe   <= 1'b1;
            r_ldAddr <= 8'd0;
            r_twConj <= bus.inv;
            r_cnt    <= 8'd1;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_ldWe <= 1'b1;
            if (bus.sop_in) begin
              r_ldAddr <= 8'd0;
              r_twConj <= bus.inv;
              r_cnt    <= 8'd1;
              r_sopErr <= 1'b1;
            end else begin
              r_ldAddr <= bitrev8(r_cnt);
              if (r_cnt == 8'(N - 1)) begin
                r_inReady <= 1'b0;
                r_stage   <= '0;
                r_bfEn    <= 1'b1;
                {r_rdP, r_rdQ, r_twAddr} <= bflyAddr(7'd0, 3'd0);
                r_cnt     <= 8'd1;
                r_state   <= S_CALC;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
        end
        S_CALC: begin
          r_bfEn <= 1'b1;
          {r_rdP, r_rdQ, r_twAddr} <= bflyAddr(r_cnt[6:0], r_stage);
          if (r_cnt == 8'(N / 2 - 1)) begin
            r_drain <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // The exit cycle itself issues the next stage's first read so the gap is exactly BF_LAT.
        S_DRAIN: begin
          if (r_drain == 4'(BF_LAT)) begin
            r_cnt <= 8'd1;
            if (r_stage == 3'(LOGN - 1)) begin
              r_outRe   <= 1'b1;
              r_outAddr <= 8'd0;
              r_state   <= S_OUT;
            end else begin
              r_stage <= r_stage + 3'd1;
              r_bfEn  <= 1'b1;
              {r_rdP, r_rdQ, r_twAddr} <= bflyAddr(7'd0, r_stage + 3'd1);
              r_state <= S_CALC;
            end
          end else begin
            r_drain <= r_drain + 4'd1;
          end
        end
        S_OUT: begin
          r_outRe   <= 1'b1;
          r_outAddr <= r_cnt;
          if (r_cnt == 8'(N - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipeEn <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        r_pipeP[i] <= '0;
        r_pipeQ[i] <= '0;
      end
    end else begin
      r_pipeEn[0] <= r_bfEn;
      r_pipeP[0]  <= r_rdP;
      r_pipeQ[0]  <= r_rdQ;
      for (int i = 1; i < BF_LAT; i++) begin
        r_pipeEn[i] <= r_pipeEn[i-1];
        r_pipeP[i]  <= r_pipeP[i-1];
        r_pipeQ[i]  <= r_pipeQ[i-1];
      end
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.ld_we     = r_ldWe;
  assign bus.ld_addr   = r_ldAddr;
  assign bus.bf_en     = r_bfEn;
  assign bus.rd_addr_p = r_rdP;
  assign bus.rd_addr_q = r_rdQ;
  assign bus.tw_addr   = r_twAddr;
  assign bus.tw_conj   = r_twConj;
  assign bus.wb_en     = r_pipeEn[BF_LAT-1];
  assign bus.wb_addr_p = r_pipeP[BF_LAT-1];
  assign bus.wb_addr_q = r_pipeQ[BF_LAT-1];
  assign bus.stage     = r_stage;
  assign bus.out_re    = r_outRe;
  assign bus.out_addr  = r_outAddr;
  assign bus.valid_out = r_validOut;
  assign bus.sop_out   = r_sopOut;
  assign bus.busy      = r_busy;
  assign bus.sop_err   = r_sopErr;

`ifdef FFT256_CTRL_SCALE_EN
  assign bus.bf_scale = r_bfEn;
`else
  assign bus.bf_scale = 1'b0;
`endif

endmodule
